// File: rtl/pdes_pkg.sv
// Shared PHOLD definitions: timestamp width, the saturated timestamp value and
// the GVT tracker state encoding seen by the personality control FSM.
package pdes_pkg;

    localparam int TIME_W_DEF = 14;
    localparam logic [TIME_W_DEF-1:0] TIME_MAX = {TIME_W_DEF{1'b1}};

    typedef enum logic [1:0] {
        GVT_IDLE   = 2'd0,
        GVT_SCAN   = 2'd1,
        GVT_UPDATE = 2'd2,
        GVT_DONE   = 2'd3
    } gvt_state_e;

endpackage

// File: rtl/gvt_tracker.sv
// Global virtual time tracker: serially scans busy cores plus the queue head,
// publishes a monotonic GVT and pulses rtn_vld once GVT reaches end_time.
module gvt_tracker
    import pdes_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int TIME_W    = TIME_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [TIME_W-1:0]           end_time,
    input  logic [NUM_CORES-1:0]        core_vld,
    input  logic [NUM_CORES*TIME_W-1:0] core_time,
    input  logic                        q_empty,
    input  logic [TIME_W-1:0]           q_min_time,
    output logic [TIME_W-1:0]           gvt,
    output logic                        gvt_upd,
    output logic                        rtn_vld,
    output logic                        err_regress
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CORES - 1);
    localparam logic [TIME_W-1:0] T_MAX    = {TIME_W{1'b1}};

    gvt_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TIME_W-1:0] run_min_q, run_min_d;
    logic [TIME_W-1:0] gvt_q, gvt_d;
    logic              gvt_upd_q, gvt_upd_d;
    logic              rtn_vld_q, rtn_vld_d;
    logic              err_q, err_d;

    logic [TIME_W-1:0] seed;
    logic [TIME_W-1:0] cand;
    logic [TIME_W-1:0] core_sel_time;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        run_min_d     = run_min_q;
        gvt_d         = gvt_q;
        gvt_upd_d     = 1'b0;
        rtn_vld_d     = 1'b0;
        err_d         = err_q;
        seed          = q_empty ? T_MAX : q_min_time;
        cand          = (run_min_q < end_time) ? run_min_q : end_time;
        core_sel_time = core_time[int'(idx_q)*TIME_W +: TIME_W];

        unique case (state_q)
            GVT_IDLE: begin
                run_min_d = seed;
                idx_d     = '0;
                state_d   = GVT_SCAN;
            end
            GVT_SCAN: begin
                if (core_vld[idx_q] && (core_sel_time < run_min_q)) begin
                    run_min_d = core_sel_time;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = GVT_UPDATE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            GVT_UPDATE: begin
                if (cand > gvt_q) begin
                    gvt_d     = cand;
                    gvt_upd_d = 1'b1;
                end else if (cand < gvt_q) begin
                    err_d = 1'b1;
                end
                // The queue head is re-sampled here, so the next round's seed
                // is taken in the same cycle as this round's decision.
                if (cand >= end_time) begin
                    state_d   = GVT_DONE;
                    rtn_vld_d = 1'b1;
                end else begin
                    run_min_d = seed;
                    idx_d     = '0;
                    state_d   = GVT_SCAN;
                end
            end
            GVT_DONE: begin
                state_d = GVT_DONE;
            end
            default: begin
                state_d = GVT_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= GVT_IDLE;
            idx_q     <= '0;
            run_min_q <= T_MAX;
            gvt_q     <= '0;
            gvt_upd_q <= 1'b0;
            rtn_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            run_min_q <= run_min_d;
            gvt_q     <= gvt_d;
            gvt_upd_q <= gvt_upd_d;
            rtn_vld_q <= rtn_vld_d;
            err_q     <= err_d;
        end
    end

    assign gvt         = gvt_q;
    assign gvt_upd     = gvt_upd_q;
    assign rtn_vld     = rtn_vld_q;
    assign err_regress = err_q;

endmodule

// File: tb/tb_gvt_tracker.sv
// Self-checking bench for gvt_tracker: directed scenarios plus randomized rounds
// checked against a round-level sampling model of the GVT rules.
module tb_gvt_tracker;

    localparam int N  = 4;
    localparam int TW = 14;
    localparam logic [TW-1:0] TMAX = '1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [TW-1:0]     end_time = '0;
    logic [N-1:0]      core_vld = '0;
    logic [TW-1:0]     ct [N];
    logic [N*TW-1:0]   core_time;
    logic              q_empty = 1'b1;
    logic [TW-1:0]     q_min_time = '0;
    logic [TW-1:0]     gvt;
    logic              gvt_upd;
    logic              rtn_vld;
    logic              err_regress;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always_comb begin
        core_time = '0;
        for (int i = 0; i < N; i++) core_time[i*TW +: TW] = ct[i];
    end

    gvt_tracker #(.NUM_CORES(N), .TIME_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .end_time   (end_time),
        .core_vld   (core_vld),
        .core_time  (core_time),
        .q_empty    (q_empty),
        .q_min_time (q_min_time),
        .gvt        (gvt),
        .gvt_upd    (gvt_upd),
        .rtn_vld    (rtn_vld),
        .err_regress(err_regress)
    );

    // Reference model. Active cycles are numbered from 0 (first edge with
    // rst_n high). Each round of N+1 cycles collects samples: the queue head at
    // the round's first cycle, then core i one cycle after the previous core.
    // Every later multiple of N+1 is a decision cycle that also starts a round.
    int            m_c = 0;
    logic [TW-1:0] m_gvt = '0;
    logic          m_err = 1'b0;
    logic          m_done = 1'b0;
    logic          m_upd = 1'b0;
    logic          m_rtn = 1'b0;
    logic          m_update = 1'b0;
    logic [TW-1:0] m_samples [$];

    task automatic model_step();
        int p;
        logic [TW-1:0] c;
        m_upd = 1'b0;
        m_rtn = 1'b0;
        m_update = 1'b0;
        if (!rst_n) begin
            m_c = 0;
            m_gvt = '0;
            m_err = 1'b0;
            m_done = 1'b0;
            m_samples.delete();
            return;
        end
        if (m_done) return;
        p = m_c % (N + 1);
        if (p == 0) begin
            if (m_c > 0) begin
                m_update = 1'b1;
                c = end_time;
                foreach (m_samples[j]) if (m_samples[j] < c) c = m_samples[j];
                if (c > m_gvt) begin
                    m_gvt = c;
                    m_upd = 1'b1;
                end else if (c < m_gvt) begin
                    m_err = 1'b1;
                end
                if (c >= end_time) begin
                    m_done = 1'b1;
                    m_rtn = 1'b1;
                end
            end
            m_samples.delete();
            if (!q_empty) m_samples.push_back(q_min_time);
        end else if (core_vld[p-1]) begin
            m_samples.push_back(ct[p-1]);
        end
        m_c++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wait_update(input string tag);
        bit got = 1'b0;
        for (int k = 0; k < 3 * (N + 1); k++) begin
            tick();
            if (m_update) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_fail++;
            $display("FAIL %s no decision cycle within budget", tag);
        end
    endtask

    task automatic set_cores(input int a, input int b, input int c, input int d);
        core_vld = '1;
        ct[0] = TW'(a);
        ct[1] = TW'(b);
        ct[2] = TW'(c);
        ct[3] = TW'(d);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        set_cores(7, 8, 9, 10);
        q_empty = 1'b0;
        q_min_time = 14'd3;
        end_time = 14'd50;
        do_reset();
        n_tests++; if (gvt !== 14'd0) begin n_fail++; $display("FAIL reset_gvt got=%0d exp=0", gvt); end
        n_tests++; if (gvt_upd !== 1'b0) begin n_fail++; $display("FAIL reset_upd got=%b exp=0", gvt_upd); end
        n_tests++; if (rtn_vld !== 1'b0) begin n_fail++; $display("FAIL reset_rtn got=%b exp=0", rtn_vld); end
        n_tests++; if (err_regress !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_regress); end
    endtask

    task automatic test_empty();
        do_reset();
        end_time = 14'd100;
        core_vld = '0;
        q_empty = 1'b1;
        rst_n = 1'b1;
        repeat (N + 1) tick();
        n_tests++; if (gvt !== 14'd0) begin n_fail++; $display("FAIL empty_early_gvt got=%0d exp=0", gvt); end
        n_tests++; if (rtn_vld !== 1'b0) begin n_fail++; $display("FAIL empty_early_rtn got=%b exp=0", rtn_vld); end
        tick();
        n_tests++; if (gvt !== 14'd100) begin n_fail++; $display("FAIL empty_gvt got=%0d exp=100", gvt); end
        n_tests++; if (gvt_upd !== 1'b1) begin n_fail++; $display("FAIL empty_upd got=%b exp=1", gvt_upd); end
        n_tests++; if (rtn_vld !== 1'b1) begin n_fail++; $display("FAIL empty_rtn got=%b exp=1", rtn_vld); end
        tick();
        n_tests++; if (rtn_vld !== 1'b0) begin n_fail++; $display("FAIL empty_rtn_once got=%b exp=0", rtn_vld); end
        n_tests++; if (gvt_upd !== 1'b0) begin n_fail++; $display("FAIL empty_upd_once got=%b exp=0", gvt_upd); end
        repeat (2 * (N + 1)) tick();
        n_tests++; if (gvt !== 14'd100) begin n_fail++; $display("FAIL empty_done_gvt got=%0d exp=100", gvt); end
        n_tests++; if (rtn_vld !== 1'b0) begin n_fail++; $display("FAIL empty_done_rtn got=%b exp=0", rtn_vld); end
    endtask

    task automatic test_progression_regression();
        do_reset();
        end_time = 14'd1000;
        set_cores(40, 25, 60, 90);
        q_empty = 1'b0;
        q_min_time = 14'd30;
        rst_n = 1'b1;
        wait_update("prog_r1");
        n_tests++; if (gvt !== 14'd25) begin n_fail++; $display("FAIL prog_gvt25 got=%0d exp=25", gvt); end
        n_tests++; if (gvt_upd !== 1'b1) begin n_fail++; $display("FAIL prog_upd25 got=%b exp=1", gvt_upd); end
        n_tests++; if (rtn_vld !== 1'b0) begin n_fail++; $display("FAIL prog_rtn25 got=%b exp=0", rtn_vld); end
        ct[1] = 14'd35;
        wait_update("prog_r2");
        n_tests++; if (gvt !== 14'd30) begin n_fail++; $display("FAIL prog_gvt30 got=%0d exp=30", gvt); end
        n_tests++; if (gvt_upd !== 1'b1) begin n_fail++; $display("FAIL prog_upd30 got=%b exp=1", gvt_upd); end
        wait_update("prog_r3");
        n_tests++; if (gvt_upd !== 1'b0) begin n_fail++; $display("FAIL prog_hold_upd got=%b exp=0", gvt_upd); end
        n_tests++; if (err_regress !== 1'b0) begin n_fail++; $display("FAIL prog_hold_err got=%b exp=0", err_regress); end
        ct[2] = 14'd20;
        wait_update("regr_r1");
        n_tests++; if (err_regress !== 1'b1) begin n_fail++; $display("FAIL regr_err got=%b exp=1", err_regress); end
        n_tests++; if (gvt !== 14'd30) begin n_fail++; $display("FAIL regr_gvt got=%0d exp=30", gvt); end
        n_tests++; if (gvt_upd !== 1'b0) begin n_fail++; $display("FAIL regr_upd got=%b exp=0", gvt_upd); end
        ct[2] = 14'd50;
        wait_update("regr_r2");
        n_tests++; if (err_regress !== 1'b1) begin n_fail++; $display("FAIL regr_sticky got=%b exp=1", err_regress); end
        n_tests++; if (gvt !== 14'd30) begin n_fail++; $display("FAIL regr_gvt2 got=%0d exp=30", gvt); end
    endtask

    task automatic test_finish();
        do_reset();
        end_time = 14'd500;
        set_cores(300, 300, 300, 300);
        q_empty = 1'b0;
        q_min_time = 14'd300;
        rst_n = 1'b1;
        wait_update("fin_r1");
        n_tests++; if (gvt !== 14'd300) begin n_fail++; $display("FAIL fin_gvt300 got=%0d exp=300", gvt); end
        set_cores(620, 620, 620, 620);
        q_min_time = 14'd620;
        // The queue seed for this round was taken at the previous decision.
        wait_update("fin_r2");
        n_tests++; if (gvt !== 14'd300) begin n_fail++; $display("FAIL fin_seed_gvt got=%0d exp=300", gvt); end
        n_tests++; if (rtn_vld !== 1'b0) begin n_fail++; $display("FAIL fin_seed_rtn got=%b exp=0", rtn_vld); end
        wait_update("fin_r3");
        n_tests++; if (gvt !== 14'd500) begin n_fail++; $display("FAIL fin_gvt500 got=%0d exp=500", gvt); end
        n_tests++; if (gvt_upd !== 1'b1) begin n_fail++; $display("FAIL fin_upd got=%b exp=1", gvt_upd); end
        n_tests++; if (rtn_vld !== 1'b1) begin n_fail++; $display("FAIL fin_rtn got=%b exp=1", rtn_vld); end
        tick();
        n_tests++; if (rtn_vld !== 1'b0) begin n_fail++; $display("FAIL fin_rtn_once got=%b exp=0", rtn_vld); end
        set_cores(10, 10, 10, 10);
        q_min_time = 14'd5;
        repeat (3 * (N + 1)) tick();
        n_tests++; if (gvt !== 14'd500) begin n_fail++; $display("FAIL fin_frozen_gvt got=%0d exp=500", gvt); end
        n_tests++; if (err_regress !== 1'b0) begin n_fail++; $display("FAIL fin_frozen_err got=%b exp=0", err_regress); end
        n_tests++; if (rtn_vld !== 1'b0 || gvt_upd !== 1'b0) begin
            n_fail++; $display("FAIL fin_quiet got=%b%b exp=00", rtn_vld, gvt_upd);
        end
    endtask

    task automatic test_reset_mid_round();
        do_reset();
        end_time = 14'd1000;
        set_cores(50, 50, 50, 50);
        q_empty = 1'b1;
        rst_n = 1'b1;
        wait_update("mid_r1");
        n_tests++; if (gvt !== 14'd50) begin n_fail++; $display("FAIL mid_pre_gvt got=%0d exp=50", gvt); end
        set_cores(70, 70, 70, 70);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        n_tests++; if (gvt !== 14'd0) begin n_fail++; $display("FAIL midscan_gvt got=%0d exp=0", gvt); end
        n_tests++; if (gvt_upd !== 1'b0 || rtn_vld !== 1'b0) begin
            n_fail++; $display("FAIL midscan_pulses got=%b%b exp=00", gvt_upd, rtn_vld);
        end
        rst_n = 1'b1;
        repeat (N + 1) tick();
        n_tests++; if (gvt !== 14'd0) begin n_fail++; $display("FAIL midscan_restart_early got=%0d exp=0", gvt); end
        tick();
        n_tests++; if (gvt !== 14'd70) begin n_fail++; $display("FAIL midscan_restart_gvt got=%0d exp=70", gvt); end
        n_tests++; if (gvt_upd !== 1'b1) begin n_fail++; $display("FAIL midscan_restart_upd got=%b exp=1", gvt_upd); end
        set_cores(90, 90, 90, 90);
        repeat (N) tick();
        rst_n = 1'b0;
        tick();
        n_tests++; if (gvt_upd !== 1'b0) begin n_fail++; $display("FAIL midupd_upd got=%b exp=0", gvt_upd); end
        n_tests++; if (gvt !== 14'd0) begin n_fail++; $display("FAIL midupd_gvt got=%0d exp=0", gvt); end
    endtask

    task automatic test_bounds();
        do_reset();
        end_time = 14'd0;
        set_cores(5, 5, 5, 5);
        q_empty = 1'b1;
        rst_n = 1'b1;
        wait_update("bnd_zero");
        n_tests++; if (gvt !== 14'd0) begin n_fail++; $display("FAIL bnd_zero_gvt got=%0d exp=0", gvt); end
        n_tests++; if (gvt_upd !== 1'b0) begin n_fail++; $display("FAIL bnd_zero_upd got=%b exp=0", gvt_upd); end
        n_tests++; if (rtn_vld !== 1'b1) begin n_fail++; $display("FAIL bnd_zero_rtn got=%b exp=1", rtn_vld); end
        do_reset();
        end_time = TMAX;
        set_cores(16382, 16382, 16382, 16382);
        q_empty = 1'b1;
        rst_n = 1'b1;
        wait_update("bnd_max1");
        n_tests++; if (gvt !== 14'd16382) begin n_fail++; $display("FAIL bnd_max_gvt got=%0d exp=16382", gvt); end
        n_tests++; if (gvt_upd !== 1'b1) begin n_fail++; $display("FAIL bnd_max_upd got=%b exp=1", gvt_upd); end
        n_tests++; if (rtn_vld !== 1'b0) begin n_fail++; $display("FAIL bnd_max_rtn got=%b exp=0", rtn_vld); end
        wait_update("bnd_max2");
        n_tests++; if (rtn_vld !== 1'b0 || gvt_upd !== 1'b0) begin
            n_fail++; $display("FAIL bnd_max_hold got=%b%b exp=00", rtn_vld, gvt_upd);
        end
        core_vld = '0;
        wait_update("bnd_drain");
        n_tests++; if (gvt !== TMAX) begin n_fail++; $display("FAIL bnd_drain_gvt got=%0d exp=%0d", gvt, TMAX); end
        n_tests++; if (rtn_vld !== 1'b1) begin n_fail++; $display("FAIL bnd_drain_rtn got=%b exp=1", rtn_vld); end
    endtask

    task automatic test_random();
        int base;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            base = int'($urandom_range(0, 400));
            end_time = (r == 5) ? TMAX : TW'(base + int'($urandom_range(0, 1500)));
            rst_n = 1'b1;
            for (int k = 0; k < 150; k++) begin
                base += int'($urandom_range(0, 12));
                for (int i = 0; i < N; i++) ct[i] = TW'(base + int'($urandom_range(0, 120)));
                core_vld = N'($urandom);
                q_empty = ($urandom_range(0, 3) == 0);
                q_min_time = TW'(base + int'($urandom_range(0, 120)));
                if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                n_tests++; if (gvt !== m_gvt) begin n_fail++; $display("FAIL rnd_gvt r=%0d k=%0d got=%0d exp=%0d", r, k, gvt, m_gvt); end
                n_tests++; if (gvt_upd !== m_upd) begin n_fail++; $display("FAIL rnd_upd r=%0d k=%0d got=%b exp=%b", r, k, gvt_upd, m_upd); end
                n_tests++; if (rtn_vld !== m_rtn) begin n_fail++; $display("FAIL rnd_rtn r=%0d k=%0d got=%b exp=%b", r, k, rtn_vld, m_rtn); end
                n_tests++; if (err_regress !== m_err) begin n_fail++; $display("FAIL rnd_err r=%0d k=%0d got=%b exp=%b", r, k, err_regress, m_err); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) ct[i] = '0;
        test_reset();
        test_empty();
        test_progression_regression();
        test_finish();
        test_reset_mid_round();
        test_bounds();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gvt_tracker.md
Name: gvt_tracker

Overview:
Computes the global virtual time (GVT) for the PHOLD engine and detects simulation completion.
It sits inside phold, directly upstream of the personality control FSM, and drives that FSM's gvt/rtn_vld inputs.
It continuously takes the minimum timestamp over busy cores and the event-queue head, and publishes a monotonic GVT.
When GVT reaches end_time, it pulses rtn_vld once.

Parameters:
NUM_CORES, 4, number of PHOLD event-processing cores scanned (>=1).
TIME_W, 14, timestamp width in bits (unsigned).

Ports:
clk  input  1  core clock; single clock domain.
rst_n  input  1  synchronous, active-low reset; deasserted only while the personality FSM is RUNNING.
end_time  input  TIME_W  simulation end timestamp; static while rst_n=1.
core_vld  input  NUM_CORES  bit i=1: core i holds an in-flight event.
core_time  input  NUM_CORES*TIME_W  core i's event timestamp at bits [i*TIME_W +: TIME_W].
q_empty  input  1  event queue empty.
q_min_time  input  TIME_W  timestamp at the queue head; valid when q_empty=0.
gvt  output  TIME_W  current GVT.
gvt_upd  output  1  one-cycle pulse when gvt increases.
rtn_vld  output  1  one-cycle pulse: simulation finished, gvt final.
err_regress  output  1  sticky: a computed candidate fell below the current gvt.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - state=IDLE, gvt=0, gvt_upd=0, rtn_vld=0, err_regress=0, idx=0, run_min=TIME_MAX.
- States: IDLE, SCAN, UPDATE, DONE.
- IDLE: first cycle with rst_n=1.
  - Seed run_min = q_empty ? TIME_MAX : q_min_time.
  - idx=0; go to SCAN.
- SCAN: one core per cycle.
  - If core_vld[idx] and core_time[idx] < run_min, then run_min = core_time[idx].
  - If idx==NUM_CORES-1, go to UPDATE; else idx++.
  - Cores are sampled non-atomically. Cores guarantee a core's timestamp never drops below the queue min it dequeued from.
- UPDATE: cand = min(run_min, end_time). This covers the drained case: run_min=TIME_MAX gives cand=end_time.
  - cand > gvt: gvt<=cand, gvt_upd=1 next cycle.
  - cand < gvt: gvt held, err_regress<=1 (sticky until reset), no pulse.
  - cand == gvt: no change.
  - If cand >= end_time: go to DONE and pulse rtn_vld (registered, same cycle as any gvt_upd).
  - Otherwise re-seed run_min, idx=0, go to SCAN.
- DONE: gvt frozen, outputs quiescent; remain until rst_n=0.
- Round latency: NUM_CORES+1 cycles between UPDATE cycles. First UPDATE occurs NUM_CORES+1 cycles after rst_n rises.
- All comparisons are unsigned TIME_W; no wrap-around. end_time=TIME_MAX is legal and finishes only when the system drains.
- end_time=0: first UPDATE gives cand=0. No gvt_upd; rtn_vld pulses.
- Reset mid-SCAN or mid-UPDATE: synchronous abort to reset values; no pulse is emitted that cycle.
- All outputs are registered.

Decomposition:
- Shared package pdes_pkg holds:
  - TIME_W default;
  - TIME_MAX = {TIME_W{1'b1}};
  - the state encoding localparams shared with the personality FSM.
- No sub-module: the single comparator and index mux stay inline.
- If timing fails at large NUM_CORES, split the scan into a gvt_min_tree sub-module (pipelined pairwise min). Round latency must then be re-specified.

Test Plan:
- Empty system (all core_vld=0, q_empty=1, end_time=100):
  - First UPDATE sets gvt=100 with gvt_upd and rtn_vld asserted together, at cycle NUM_CORES+2 after rst_n rises.
  - Stays in DONE.
- Progression (end_time=1000; core_time={40,25,60,90}, all valid; q_min_time=30):
  - gvt=25 with gvt_upd.
  - Raise core1 time to 35 → next round gvt=30.
- Regression (gvt=30; force core2 time to 20):
  - err_regress=1 and gvt stays 30.
  - Restore core2 to 50 → err_regress remains 1.
- Finish: with end_time=500, min reaches 620 → gvt=500 and rtn_vld one cycle. Later input changes do not move gvt.
- Reset mid-SCAN (rst_n low at idx=2):
  - Next cycle gvt=0 and all pulses 0.
  - After release, the full round restarts from idx=0.
- Bounds: end_time=0 → rtn_vld with gvt=0 and no gvt_upd. TIME_MAX (16383) with all cores valid at 16382 → gvt=16382 and no rtn_vld.
